// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM state encoding and counter width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Wait counter width; covers LATENCY-1 for LATENCY up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// Data-cache request/response bundle between a requester and dmem_responder.
// Latency: n/a (wires only).
// Backpressure: stall from the responder holds the requester on its current request.
interface dmem_responder_if;

  logic [31:0] dcache_addr;
  logic [3:0]  dcache_we;
  logic        dcache_re;
  logic [31:0] dcache_din;
  logic [31:0] dcache_dout;
  logic        stall;

  modport master (
    output dcache_addr, dcache_we, dcache_re, dcache_din,
    input  dcache_dout, stall
  );

  modport slave (
    input  dcache_addr, dcache_we, dcache_re, dcache_din,
    output dcache_dout, stall
  );

endinterface

// File: rtl/dmem_sram_1rw.sv
// Single-port word SRAM with byte-write mask and synchronous read-before-write.
// Latency: read data registered at the access edge, visible the following cycle.
// Backpressure: none; every enabled access is performed at its edge.
module dmem_sram_1rw #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [AW-1:0] idx,
  input  logic [3:0]    be,
  input  logic          re,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-masked write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read register: samples the pre-write word and holds it until the next read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata <= '0;
    end else if (en && re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one read/write request, waits LATENCY cycles, then accesses the SRAM.
// Latency: LATENCY+1 stall cycles per access (0 stalls when LATENCY==0); read data valid the cycle after the access edge.
// Backpressure: stall high holds the requester; optional stat counters under DMEM_RESPONDER_STAT_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus
`ifdef DMEM_RESPONDER_STAT_EN
  ,
  output logic [31:0]       stat_reads,
  output logic [31:0]       stat_writes
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic [AW-1:0]    cap_idx;
  logic [3:0]       cap_we;
  logic             cap_re;
  logic [31:0]      cap_din;

  logic             req;
  logic [AW-1:0]    live_idx;
  logic             stall_c;
  logic             capture;
  logic             acc_live;
  logic             acc_cap;

  logic             acc_en;
  logic [AW-1:0]    acc_idx;
  logic [3:0]       acc_we;
  logic             acc_re;
  logic [31:0]      acc_din;

  logic             unused_addr_bits;

  assign req      = bus.dcache_re | (|bus.dcache_we);
  assign live_idx = bus.dcache_addr[AW+1:2];
  assign unused_addr_bits = ^{bus.dcache_addr[31:AW+2], bus.dcache_addr[1:0]};

  // Next-state, counter and control decode; defaults hold state and assert nothing.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_c   = 1'b0;
    capture   = 1'b0;
    acc_live  = 1'b0;
    acc_cap   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (LATENCY == 0) begin
            acc_live = 1'b1;
          end else begin
            stall_c   = 1'b1;
            capture   = 1'b1;
            cnt_nxt   = CNT_LOAD;
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (cnt == '0) begin
          acc_cap   = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DONE: begin
        // The still-held request was already serviced; drop back without re-accepting.
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Access source: live bus for zero-latency, captured request otherwise; reset aborts any access.
  always_comb begin
    acc_en  = reset & (acc_live | acc_cap);
    acc_idx = acc_cap ? cap_idx : live_idx;
    acc_we  = acc_cap ? cap_we  : bus.dcache_we;
    acc_re  = acc_cap ? cap_re  : bus.dcache_re;
    acc_din = acc_cap ? cap_din : bus.dcache_din;
  end

  assign bus.stall = reset & stall_c;

  // State and wait-counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request capture at the accept edge; consumed only from BUSY so no reset is needed.
  always_ff @(posedge clk) begin
    if (capture) begin
      cap_idx <= live_idx;
      cap_we  <= bus.dcache_we;
      cap_re  <= bus.dcache_re;
      cap_din <= bus.dcache_din;
    end
  end

  dmem_sram_1rw #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_sram (
    .clk   (clk),
    .reset (reset),
    .en    (acc_en),
    .idx   (acc_idx),
    .be    (acc_we),
    .re    (acc_re),
    .wdata (acc_din),
    .rdata (bus.dcache_dout)
  );

`ifdef DMEM_RESPONDER_STAT_EN
  // Saturating counts of completed read and write accesses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_reads  <= '0;
      stat_writes <= '0;
    end else if (acc_en) begin
      if (acc_re && (stat_reads != 32'hFFFF_FFFF))   stat_reads  <= stat_reads + 32'd1;
      if ((|acc_we) && (stat_writes != 32'hFFFF_FFFF)) stat_writes <= stat_writes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench: LATENCY=0 and LATENCY=2 instances against a word-array model with a read scoreboard.
// Latency: n/a.
// Backpressure: driver holds each request until stall is low.
module tb_dmem_responder;

  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] addr_v [2];
  logic [31:0] din_v  [2];
  logic [3:0]  we_v   [2];
  logic        re_v   [2];

  dmem_responder_if bus0 ();
  dmem_responder_if bus2 ();

  assign bus0.dcache_addr = addr_v[0];
  assign bus0.dcache_din  = din_v[0];
  assign bus0.dcache_we   = we_v[0];
  assign bus0.dcache_re   = re_v[0];
  assign bus2.dcache_addr = addr_v[1];
  assign bus2.dcache_din  = din_v[1];
  assign bus2.dcache_we   = we_v[1];
  assign bus2.dcache_re   = re_v[1];

`ifdef DMEM_RESPONDER_STAT_EN
  logic [31:0] st_rd0, st_wr0, st_rd2, st_wr2;
`endif

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
`ifdef DMEM_RESPONDER_STAT_EN
    , .stat_reads (st_rd0), .stat_writes (st_wr0)
`endif
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
`ifdef DMEM_RESPONDER_STAT_EN
    , .stat_reads (st_rd2), .stat_writes (st_wr2)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m0 [int];
  logic [31:0] mem_m1 [int];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  int          rd_cnt [2];
  int          wr_cnt [2];

  int          run     [2];
  logic        pend    [2];
  logic [31:0] last_rd [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_rd(input int k, input int idx);
    if (k == 0) return mem_m0.exists(idx) ? mem_m0[idx] : 32'hxxxx_xxxx;
    return mem_m1.exists(idx) ? mem_m1[idx] : 32'hxxxx_xxxx;
  endfunction

  task automatic m_wr(input int k, input int idx, input logic [3:0] we, input logic [31:0] din);
    logic [31:0] w;
    w = m_rd(k, idx);
    for (int b = 0; b < 4; b++) if (we[b]) w[8*b +: 8] = din[8*b +: 8];
    if (k == 0) mem_m0[idx] = w;
    else        mem_m1[idx] = w;
  endtask

  function automatic logic get_stall(input int k);
    return (k == 0) ? bus0.stall : bus2.stall;
  endfunction

  // Issue one request on instance k, update the model, hold until stall is low.
  task automatic do_txn(input int k, input logic [31:0] addr, input logic [3:0] we,
                        input logic re, input logic [31:0] din);
    int idx;
    int n;
    idx = int'((addr >> 2) % DEPTH);
    addr_v[k] = addr;
    we_v[k]   = we;
    re_v[k]   = re;
    din_v[k]  = din;
    if (re) begin
      if (k == 0) q0.push_back(m_rd(k, idx));
      else        q1.push_back(m_rd(k, idx));
      rd_cnt[k]++;
    end
    if (we != 4'h0) begin
      m_wr(k, idx, we, din);
      wr_cnt[k]++;
    end
    n = 0;
    forever begin
      @(negedge clk);
      if (!get_stall(k)) break;
      n++;
      if (n > 40) begin
        checks++;
        errors++;
        $display("FAIL stall_timeout inst=%0d actual=stuck required=release", k);
        break;
      end
    end
    @(posedge clk);
    #1;
    we_v[k] = 4'h0;
    re_v[k] = 1'b0;
  endtask

  // Per-instance monitor: read scoreboard, stall-length rule, dout hold rule.
  task automatic mon(input int k, input logic rst, input logic stall, input logic req,
                     input logic re, input logic [31:0] dout);
    logic popped;
    logic [31:0] e;
    popped = 1'b0;
    if (!rst) begin
      chk("reset_stall", {31'd0, stall}, 32'd0);
      run[k] = 0;
      pend[k] = 1'b0;
      last_rd[k] = 32'h0;
      return;
    end
    if (k == 0) begin
      if (pend[0]) begin
        if (q0.size() == 0) begin
          chk("lat0_unexpected_read", 32'd1, 32'd0);
        end else begin
          e = q0.pop_front();
          chk("lat0_read", dout, e);
          last_rd[0] = e;
        end
        popped = 1'b1;
        pend[0] = 1'b0;
      end
      if (stall) chk("lat0_stall", {31'd0, stall}, 32'd0);
      if (req && !stall && re) pend[0] = 1'b1;
    end else begin
      if (stall) begin
        run[1]++;
      end else begin
        if (run[1] > 0) begin
          chk("stall_run", 32'(run[1]), 32'd3);
          run[1] = 0;
        end
        if (req && re) begin
          if (q1.size() == 0) begin
            chk("lat2_unexpected_read", 32'd1, 32'd0);
          end else begin
            e = q1.pop_front();
            chk("lat2_read", dout, e);
            last_rd[1] = e;
          end
          popped = 1'b1;
        end
      end
    end
    if (!popped) chk("dout_hold", dout, last_rd[k]);
  endtask

  always @(negedge clk)
    mon(0, reset, bus0.stall, bus0.dcache_re | (|bus0.dcache_we), bus0.dcache_re, bus0.dcache_dout);

  always @(negedge clk)
    mon(1, reset, bus2.stall, bus2.dcache_re | (|bus2.dcache_we), bus2.dcache_re, bus2.dcache_dout);

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, hi;
    logic [3:0]  w;
    logic        r;
    int          idx;
    for (int k = 0; k < 2; k++) begin
      run[k] = 0; pend[k] = 1'b0; last_rd[k] = 32'h0;
      rd_cnt[k] = 0; wr_cnt[k] = 0;
      addr_v[k] = 32'h0; din_v[k] = 32'h0; we_v[k] = 4'h0; re_v[k] = 1'b0;
    end
    reset = 1'b0;

    // Request held during reset must be ignored, then accepted in the first cycle out of reset.
    for (int k = 0; k < 2; k++) begin
      addr_v[k] = 32'h0000_000C; we_v[k] = 4'hF; din_v[k] = 32'hA5A5_1234;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall0", {31'd0, bus0.stall}, 32'd0);
    chk("rst_stall2", {31'd0, bus2.stall}, 32'd0);
    chk("rst_dout0", bus0.dcache_dout, 32'h0);
    chk("rst_dout2", bus2.dcache_dout, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    fork
      do_txn(0, 32'h0000_000C, 4'hF, 1'b0, 32'hA5A5_1234);
      do_txn(1, 32'h0000_000C, 4'hF, 1'b0, 32'hA5A5_1234);
    join

    // Fill the working set (words 0..15) on both instances.
    for (int i = 0; i < 16; i++) begin
      fork
        do_txn(0, 32'(i * 4), 4'hF, 1'b0, $urandom());
        do_txn(1, 32'(i * 4), 4'hF, 1'b0, $urandom());
      join
    end
    do_txn(1, 32'h0000_000C, 4'h0, 1'b1, 32'h0);

    // LATENCY=2 directed: full write/readback, byte write, wrap, combined read+write.
    do_txn(1, 32'h0000_0040, 4'hF,    1'b0, 32'hDEAD_BEEF);
    do_txn(1, 32'h0000_0040, 4'h0,    1'b1, 32'h0);
    do_txn(1, 32'h0000_0040, 4'b0010, 1'b0, 32'h0000_AB00);
    do_txn(1, 32'h0000_0040, 4'h0,    1'b1, 32'h0);
    do_txn(1, 32'h0000_1000, 4'hF,    1'b0, 32'h1234_5678);
    do_txn(1, 32'h0000_0000, 4'h0,    1'b1, 32'h0);
    do_txn(1, 32'h0000_0004, 4'hF,    1'b1, 32'hCAFE_F00D);
    do_txn(1, 32'h0000_0004, 4'h0,    1'b1, 32'h0);

    // LATENCY=0 directed: back-to-back reads, combined access, wrap.
    do_txn(0, 32'h0000_0000, 4'h0, 1'b1, 32'h0);
    do_txn(0, 32'h0000_0004, 4'h0, 1'b1, 32'h0);
    do_txn(0, 32'h0000_0008, 4'h0, 1'b1, 32'h0);
    do_txn(0, 32'h0000_0008, 4'hF, 1'b1, 32'h1357_9BDF);
    do_txn(0, 32'h0000_1008, 4'b1001, 1'b1, 32'hEE00_0011);
    do_txn(0, 32'h0000_0008, 4'h0, 1'b1, 32'h0);

    // Reset in the second BUSY cycle of a write: write must be dropped.
    do_txn(1, 32'h0000_0080, 4'hF, 1'b0, 32'h0);
    addr_v[1] = 32'h0000_0080; we_v[1] = 4'hF; din_v[1] = 32'h5A5A_5A5A;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd_cnt[0] = 0; wr_cnt[0] = 0; rd_cnt[1] = 0; wr_cnt[1] = 0;
    @(posedge clk);
    #1;
    we_v[1] = 4'h0;
    @(negedge clk);
    chk("abort_stall", {31'd0, bus2.stall}, 32'd0);
    chk("abort_dout", bus2.dcache_dout, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    do_txn(1, 32'h0000_0080, 4'h0, 1'b1, 32'h0);

    // Randomized traffic over the working set with aliased upper address bits.
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 80; n++) begin
        idx = $urandom_range(0, 15);
        hi  = $urandom();
        a   = (hi & 32'hFFFF_F000) | 32'(idx << 2) | ($urandom() & 32'h3);
        w   = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        r   = 1'($urandom_range(0, 1));
        if (!r && w == 4'h0) r = 1'b1;
        do_txn(k, a, w, r, $urandom());
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
`ifdef DMEM_RESPONDER_STAT_EN
    chk("stat_reads0",  st_rd0, 32'(rd_cnt[0]));
    chk("stat_writes0", st_wr0, 32'(wr_cnt[0]));
    chk("stat_reads2",  st_rd2, 32'(rd_cnt[1]));
    chk("stat_writes2", st_wr2, 32'(wr_cnt[1]));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
